wptr_full: RTL and testbench

- Write-side pointer and full-flag generator for the JTAG async FIFO, in the write clock domain.
- Counterpart of the read-pointer/empty block.
- Keeps a binary write counter and publishes a Gray-coded write pointer (wptr) for synchronisation into the read domain.
- Takes a read pointer already synchronised into the write domain (sync_rptr) and produces full, almost_full, a fill-level estimate, and a sticky overflow flag.

---
 rtl/wptr_full.sv | 80 ++++++++
 tb/tb_wptr_full.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-side pointer and full-flag generator for the async FIFO (write clock domain).
// Publishes a Gray write pointer and derives full/almost_full/fill level from the synced read pointer.
module wptr_full #(
   parameter int ADDR_WIDTH = 5,
   parameter int AF_MARGIN  = 2
) (
   input  logic                  wclk,
   input  logic                  w_nrst,
   input  logic                  winc,
   input  logic                  ovf_clr,
   input  logic [ADDR_WIDTH-1:0] sync_rptr,
   output logic [ADDR_WIDTH-1:0] wptr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH-1:0] wcount,
   output logic                  overflow
);

   localparam int AW    = ADDR_WIDTH;
   localparam int DEPTH = 1 << (AW - 1);
   localparam logic [AW-1:0] AF_THRESH = AW'(DEPTH - AF_MARGIN);

   logic [AW-1:0] wbin_q,  wbin_d;
   logic [AW-1:0] wptr_q,  wptr_d;
   logic [AW-1:0] wcount_q, wcount_d;
   logic          full_q,  full_d;
   logic          almost_full_q, almost_full_d;
   logic          overflow_q, overflow_d;

   logic          we;
   logic [AW-1:0] rbin;
   logic [AW-1:0] rptr_full_cmp;

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
   generate
      for (genvar gi = 0; gi < AW; gi++) begin : g_rbin
         assign rbin[gi] = ^sync_rptr[AW-1:gi];
      end
   endgenerate

   assign rptr_full_cmp = {~sync_rptr[AW-1:AW-2], sync_rptr[AW-3:0]};

   always_comb begin
      we            = winc & ~full_q;
      wbin_d        = wbin_q + {{(AW-1){1'b0}}, we};
      wptr_d        = wbin_d ^ (wbin_d >> 1);
      full_d        = (wptr_d == rptr_full_cmp);
      wcount_d      = wbin_d - rbin;
      almost_full_d = (wcount_d >= AF_THRESH);
      // A rejected write in the same cycle as a clear keeps the flag set.
      overflow_d    = (winc & full_q) | (overflow_q & ~ovf_clr);
   end

   always_ff @(posedge wclk or negedge w_nrst) begin
      if (!w_nrst) begin
         wbin_q        <= '0;
         wptr_q        <= '0;
         wcount_q      <= '0;
         full_q        <= 1'b0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
      end else begin
         wbin_q        <= wbin_d;
         wptr_q        <= wptr_d;
         wcount_q      <= wcount_d;
         full_q        <= full_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
      end
   end

   assign wptr        = wptr_q;
   assign waddr       = {1'b0, wbin_q[AW-2:0]};
   assign full        = full_q;
   assign almost_full = almost_full_q;
   assign wcount      = wcount_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: reset, fill, overflow, drain release, wrap and async reset.
module tb_wptr_full;

   logic       wclk = 1'b0;
   logic       w_nrst;
   logic       winc;
   logic       ovf_clr;
   logic [4:0] sync_rptr;
   logic [4:0] wptr;
   logic [4:0] waddr;
   logic       full;
   logic       almost_full;
   logic [4:0] wcount;
   logic       overflow;

   int n_pass  = 0;
   int n_total = 0;
   logic [4:0] prev_wptr = 5'd0;
   logic [4:0] s1, s2;

   wptr_full #(.ADDR_WIDTH(5), .AF_MARGIN(2)) dut (
      .wclk       (wclk),
      .w_nrst     (w_nrst),
      .winc       (winc),
      .ovf_clr    (ovf_clr),
      .sync_rptr  (sync_rptr),
      .wptr       (wptr),
      .waddr      (waddr),
      .full       (full),
      .almost_full(almost_full),
      .wcount     (wcount),
      .overflow   (overflow)
   );

   always #5 wclk = ~wclk;

   function automatic logic [4:0] gray(input int n);
      logic [4:0] b;
      b = n[4:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one edge, sample 1 time unit later, and check the one-bit-change property of wptr.
   task automatic tick();
      @(posedge wclk);
      #1;
      chk("wptr_onebit", 32'($countones(wptr ^ prev_wptr) <= 1), 32'd1);
      prev_wptr = wptr;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wptr"},   32'(wptr), 32'd0);
      chk({tag, "_waddr"},  32'(waddr), 32'd0);
      chk({tag, "_full"},   32'(full), 32'd0);
      chk({tag, "_af"},     32'(almost_full), 32'd0);
      chk({tag, "_wcount"}, 32'(wcount), 32'd0);
      chk({tag, "_ovf"},    32'(overflow), 32'd0);
   endtask

   initial begin
      // 1. reset / idle
      w_nrst = 1'b0; winc = 1'b1; ovf_clr = 1'b0; sync_rptr = 5'd0;
      repeat (2) @(posedge wclk);
      #1;
      chk_all_zero("rst");
      winc = 1'b0;
      w_nrst = 1'b1;
      repeat (4) tick();
      chk("idle_wptr", 32'(wptr), 32'd0);
      chk("idle_full", 32'(full), 32'd0);

      // 2. fill 16 entries with the reader parked at 0
      for (int i = 0; i < 16; i++) begin
         winc = 1'b1;
         chk("fill_waddr", 32'(waddr), 32'(i));
         tick();
         chk("fill_wcount", 32'(wcount), 32'(i + 1));
         chk("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
         chk("fill_full", 32'(full), 32'(i + 1 == 16));
         $display("fill write %0d: wptr=%b wcount=%0d af=%0b full=%0b", i, wptr, wcount, almost_full, full);
      end
      chk("fill_wptr16", 32'(wptr), 32'b11000);

      // 3. overflow set, set-wins-over-clear, clear
      tick();
      chk("ovf_wptr", 32'(wptr), 32'b11000);
      chk("ovf_set", 32'(overflow), 32'd1);
      chk("ovf_full", 32'(full), 32'd1);
      ovf_clr = 1'b1;
      tick();
      chk("ovf_setwins", 32'(overflow), 32'd1);
      winc = 1'b0;
      tick();
      chk("ovf_clr", 32'(overflow), 32'd0);
      ovf_clr = 1'b0;
      $display("overflow sequence done: wptr=%b ovf=%0b", wptr, overflow);

      // 4. drain release by one read, then refill
      sync_rptr = 5'b00001;
      tick();
      chk("drain_full", 32'(full), 32'd0);
      chk("drain_wcount", 32'(wcount), 32'd15);
      winc = 1'b1;
      chk("refill_waddr", 32'(waddr), 32'd0);
      tick();
      chk("refill_full", 32'(full), 32'd1);
      chk("refill_wcount", 32'(wcount), 32'd16);
      winc = 1'b0;
      $display("drain/refill: wptr=%b wcount=%0d full=%0b", wptr, wcount, full);

      // 5. wrap with the reader trailing two cycles behind
      #3 w_nrst = 1'b0;
      #1 w_nrst = 1'b1;
      prev_wptr = 5'd0;
      sync_rptr = 5'd0; s1 = 5'd0; s2 = 5'd0;
      for (int i = 0; i < 40; i++) begin
         winc = 1'b1;
         tick();
         s2 = s1; s1 = wptr; sync_rptr = s2;
         chk("wrap_full", 32'(full), 32'd0);
         chk("wrap_wptr", 32'(wptr), 32'(gray(i + 1)));
         $display("wrap write %0d: wptr=%b waddr=%0d", i, wptr, waddr);
      end
      winc = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         s2 = s1; s1 = wptr; sync_rptr = s2;
      end
      chk("wrap_wcount", 32'(wcount), 32'd0);
      chk("wrap_wptr_end", 32'(wptr), 32'b01100);
      chk("wrap_waddr_end", 32'(waddr), 32'd8);

      // 6. asynchronous reset in the middle of a fill
      #3 w_nrst = 1'b0;
      #1 w_nrst = 1'b1;
      prev_wptr = 5'd0;
      sync_rptr = 5'd0;
      for (int i = 0; i < 7; i++) begin
         winc = 1'b1;
         tick();
      end
      winc = 1'b0;
      chk("mid_waddr", 32'(waddr), 32'd7);
      chk("mid_wcount", 32'(wcount), 32'd7);
      #3 w_nrst = 1'b0;
      #1;
      chk_all_zero("async_rst");
      prev_wptr = 5'd0;
      #1 w_nrst = 1'b1;
      winc = 1'b1;
      chk("post_rst_waddr", 32'(waddr), 32'd0);
      tick();
      chk("post_rst_wptr", 32'(wptr), 32'd1);
      chk("post_rst_waddr1", 32'(waddr), 32'd1);
      winc = 1'b0;
      $display("async reset recovery: wptr=%b waddr=%0d", wptr, waddr);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
